// File: rtl/doy_to_date_seq.sv
// Day-of-year to month/day converter: walks a month-length table, then splits the day into BCD.
// Optional macro DOY_SEVSEG_OUT_EN adds registered active-low seven-segment outputs.
module doy_to_date_seq #(
  parameter int DOY_W         = 9,
  parameter int FEB_LEAP_DAYS = 29
) (
  input  logic             ADC_CLK_10,
  input  logic             rst,
  input  logic             start,
  input  logic [DOY_W-1:0] day_of_year,
  input  logic             leap,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       month,
  output logic [4:0]       day,
  output logic [3:0]       month_tens,
  output logic [3:0]       month_ones,
  output logic [3:0]       day_tens,
  output logic [3:0]       day_ones
`ifdef DOY_SEVSEG_OUT_EN
  ,
  output logic [7:0]       hex_mon_t,
  output logic [7:0]       hex_mon_o,
  output logic [7:0]       hex_day_t,
  output logic [7:0]       hex_day_o
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, SPLIT = 2'd2} state_t;

  function automatic logic [DOY_W-1:0] dim(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                    dim = lp ? DOY_W'(FEB_LEAP_DAYS) : DOY_W'(28);
      4'd4, 4'd6, 4'd9, 4'd11: dim = DOY_W'(30);
      default:                 dim = DOY_W'(31);
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [DOY_W-1:0] rem_q, rem_d;
  logic             leap_q, leap_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       tens_q, tens_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [3:0]       month_q, month_d;
  logic [4:0]       day_q, day_d;
  logic [3:0]       month_tens_q, month_tens_d;
  logic [3:0]       month_ones_q, month_ones_d;
  logic [3:0]       day_tens_q, day_tens_d;
  logic [3:0]       day_ones_q, day_ones_d;
  logic [DOY_W-1:0] max_doy;
  logic [DOY_W-1:0] cur_dim;

  assign max_doy = leap ? DOY_W'(366) : DOY_W'(365);
  assign cur_dim = dim(cnt_q, leap_q);

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    leap_d       = leap_q;
    cnt_d        = cnt_q;
    tens_d       = tens_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    month_d      = month_q;
    day_d        = day_q;
    month_tens_d = month_tens_q;
    month_ones_d = month_ones_q;
    day_tens_d   = day_tens_q;
    day_ones_d   = day_ones_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d  = day_of_year;
          leap_d = leap;
          cnt_d  = 4'd1;
          tens_d = 4'd0;
          if ((day_of_year != DOY_W'(0)) && (day_of_year <= max_doy)) begin
            state_d = WALK;
            busy_d  = 1'b1;
          end else begin
            // Invalid input: flag it immediately, leave the displayed date alone
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WALK: begin
        if (rem_q > cur_dim) begin
          rem_d = rem_q - cur_dim;
          cnt_d = cnt_q + 4'd1;
        end else begin
          state_d = SPLIT;
        end
      end
      SPLIT: begin
        if (rem_q >= DOY_W'(10)) begin
          rem_d  = rem_q - DOY_W'(10);
          tens_d = tens_q + 4'd1;
        end else begin
          month_d      = cnt_q;
          day_d        = (5'(tens_q) * 5'd10) + 5'(rem_q[3:0]);
          month_tens_d = (cnt_q >= 4'd10) ? 4'd1 : 4'd0;
          month_ones_d = (cnt_q >= 4'd10) ? (cnt_q - 4'd10) : cnt_q;
          day_tens_d   = tens_q;
          day_ones_d   = rem_q[3:0];
          err_d        = 1'b0;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      leap_q       <= 1'b0;
      cnt_q        <= 4'd1;
      tens_q       <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      month_q      <= 4'd1;
      day_q        <= 5'd1;
      month_tens_q <= 4'd0;
      month_ones_q <= 4'd1;
      day_tens_q   <= 4'd0;
      day_ones_q   <= 4'd1;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      leap_q       <= leap_d;
      cnt_q        <= cnt_d;
      tens_q       <= tens_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      month_q      <= month_d;
      day_q        <= day_d;
      month_tens_q <= month_tens_d;
      month_ones_q <= month_ones_d;
      day_tens_q   <= day_tens_d;
      day_ones_q   <= day_ones_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign month      = month_q;
  assign day        = day_q;
  assign month_tens = month_tens_q;
  assign month_ones = month_ones_q;
  assign day_tens   = day_tens_q;
  assign day_ones   = day_ones_q;

`ifdef DOY_SEVSEG_OUT_EN
  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  logic [7:0] hex_mon_t_q, hex_mon_o_q, hex_day_t_q, hex_day_o_q;

  // Driven from the BCD next-values so the segments update on the done edge
  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      hex_mon_t_q <= 8'hFF;
      hex_mon_o_q <= 8'hF9;
      hex_day_t_q <= 8'hFF;
      hex_day_o_q <= 8'hF9;
    end else begin
      hex_mon_t_q <= (month_tens_d == 4'd0) ? 8'hFF : seg(month_tens_d);
      hex_mon_o_q <= seg(month_ones_d);
      hex_day_t_q <= (day_tens_d == 4'd0) ? 8'hFF : seg(day_tens_d);
      hex_day_o_q <= seg(day_ones_d);
    end
  end

  assign hex_mon_t = hex_mon_t_q;
  assign hex_mon_o = hex_mon_o_q;
  assign hex_day_t = hex_day_t_q;
  assign hex_day_o = hex_day_o_q;
`endif

endmodule

// File: tb/tb_doy_to_date_seq.sv
// Scoreboard bench for doy_to_date_seq: stimulus pushes expected results, a monitor pops on done.
module tb_doy_to_date_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [8:0] day_of_year;
  logic       leap;
  logic       busy, done, err;
  logic [3:0] month;
  logic [4:0] day;
  logic [3:0] month_tens, month_ones, day_tens, day_ones;
`ifdef DOY_SEVSEG_OUT_EN
  logic [7:0] hex_mon_t, hex_mon_o, hex_day_t, hex_day_o;
`endif

  doy_to_date_seq #(.DOY_W(9), .FEB_LEAP_DAYS(29)) dut (
    .ADC_CLK_10  (clk),
    .rst         (rst),
    .start       (start),
    .day_of_year (day_of_year),
    .leap        (leap),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .month       (month),
    .day         (day),
    .month_tens  (month_tens),
    .month_ones  (month_ones),
    .day_tens    (day_tens),
    .day_ones    (day_ones)
`ifdef DOY_SEVSEG_OUT_EN
    ,
    .hex_mon_t   (hex_mon_t),
    .hex_mon_o   (hex_mon_o),
    .hex_day_t   (hex_day_t),
    .hex_day_o   (hex_day_o)
`endif
  );

  typedef struct {
    int m;
    int d;
    bit e;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   shown_m = 1, shown_d = 1;
  bit   shown_e = 0;
  int   last_m = 1, last_d = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: accumulate calendar month lengths; latency = month + day/10 + 1
  task automatic model(input int doy, input bit lp, output exp_t e);
    int dm[12];
    int r;
    int m;
    dm = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (lp) dm[1] = 29;
    if (doy < 1 || doy > 365 + int'(lp)) begin
      e.m = last_m; e.d = last_d; e.e = 1'b1; e.cyc = 0;
    end else begin
      r = doy;
      m = 0;
      while (r > dm[m]) begin
        r -= dm[m];
        m++;
      end
      e.m = m + 1; e.d = r; e.e = 1'b0; e.cyc = (m + 1) + (r / 10) + 1;
      last_m = e.m; last_d = e.d;
    end
  endtask

  // Monitor: pops on every done, otherwise checks the outputs are frozen
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("month", int'(month), e.m);
          check("day", int'(day), e.d);
          check("month_tens", int'(month_tens), e.m / 10);
          check("month_ones", int'(month_ones), e.m % 10);
          check("day_tens", int'(day_tens), e.d / 10);
          check("day_ones", int'(day_ones), e.d % 10);
          check("err", int'(err), int'(e.e));
          check("busy_at_done", int'(busy), 0);
          shown_m = e.m; shown_d = e.d; shown_e = e.e;
        end
      end else begin
        check("hold_month", int'(month), shown_m);
        check("hold_day", int'(day), shown_d);
        check("hold_err", int'(err), int'(shown_e));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Assumes caller is #1 after a rising edge; the next edge is E0
  task automatic issue(input int doy, input bit lp);
    exp_t e;
    model(doy, lp, e);
    e.cyc = cyc + 1 + e.cyc;
    exp_q.push_back(e);
    day_of_year = 9'(doy);
    leap = lp;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    day_of_year = 9'd0;
    leap = 1'b0;
    #12;
    check("rst_month", int'(month), 1);
    check("rst_day", int'(day), 1);
    check("rst_bcd", int'({month_tens, month_ones, day_tens, day_ones}), 16'h0101);
    check("rst_busy_done_err", int'({busy, done, err}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(1, 1'b0);   wait_idle();
    issue(365, 1'b0); wait_idle();
    issue(60, 1'b1);  wait_idle();
    issue(60, 1'b0);  wait_idle();
    issue(366, 1'b0); wait_idle();
    issue(0, 1'b1);   wait_idle();
    issue(366, 1'b1); wait_idle();

    // A start pulse on the third busy cycle must be ignored
    issue(200, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    day_of_year = 9'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Reset mid-walk aborts without a done pulse
    issue(300, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    exp_q.delete();
    shown_m = 1; shown_d = 1; shown_e = 1'b0;
    last_m = 1; last_d = 1;
    rst = 1'b1;
    #1;
    check("abort_month", int'(month), 1);
    check("abort_day", int'(day), 1);
    check("abort_bcd", int'({month_tens, month_ones, day_tens, day_ones}), 16'h0101);
    check("abort_busy_done", int'({busy, done}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(32, 1'b0); wait_idle();

    for (int i = 0; i < 60; i++) begin
      int d;
      bit lp;
      lp = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(1, 366));
      issue(d, lp);
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/doy_to_date_seq.md
Name: doy_to_date_seq

Overview:
- Sequential converter from day-of-year (1..365/366) to calendar month/day, with BCD digits for each field.
- Sits between the day-of-year counter and the dual seven-segment display drivers in the calendar display design.
- Walks a month-length table one month per clock, then splits the remaining day into tens/ones by repeated subtraction.
- start/done handshake; leap-year select sampled at start.

Parameters:
DOY_W, 9, width of day-of-year input (must hold 366)
FEB_LEAP_DAYS, 29, February length when leap=1 (February is 28 when leap=0)

Ports:
ADC_CLK_10  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request conversion; sampled only in IDLE
day_of_year  input  DOY_W  day number, valid 1..365 (1..366 when leap=1)
leap  input  1  leap-year select
busy  output  1  high while conversion in progress
done  output  1  one-cycle pulse, result valid
err  output  1  set with done when input invalid; held until next done
month  output  4  month 1..12, binary
day  output  5  day 1..31, binary
month_tens  output  4  BCD, 0 or 1
month_ones  output  4  BCD 0..9
day_tens  output  4  BCD 0..3
day_ones  output  4  BCD 0..9

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, err=0, month=1, day=1, month_tens=0, month_ones=1, day_tens=0, day_ones=1. Reset mid-conversion aborts with no done pulse.
- States: IDLE, WALK, SPLIT.
- Edge E0, IDLE with start=1:
  - Latch day_of_year into rem and leap into leap_q; set cnt_month=1 and tens=0.
  - If input is valid: go to WALK, busy=1.
  - If input is 0 or > 365+leap: stay in IDLE; at E0 assert done=1 and err=1 for one cycle. month/day/BCD outputs hold their previous values.
- WALK, each edge:
  - If rem > dim(cnt_month, leap_q): rem -= dim, cnt_month += 1.
  - Otherwise go to SPLIT.
  - dim: 31,28/FEB_LEAP_DAYS,31,30,31,30,31,31,30,31,30,31.
- SPLIT, each edge:
  - If rem >= 10: rem -= 10, tens += 1.
  - Otherwise, on this edge: month=cnt_month, day=tens*10+rem, BCD outputs loaded, err=0, done=1, busy=0, go to IDLE.
- Latency: done rises at edge E0 + month + day_tens + 1.
  - Jan 1 → 2 cycles.
  - Dec 31 → 16 cycles (worst case).
- done is high exactly one cycle; it is cleared on the following edge.
- start while busy is ignored. start held high in IDLE after done starts a new conversion on the next edge.
- Outputs change only on the done edge; no intermediate values are visible.
- Arithmetic: rem is DOY_W bits, never negative by construction. cnt_month never exceeds 12 for valid input.

Optional Feature:
- Macro: DOY_SEVSEG_OUT_EN
- Defined:
  - Adds registered active-low outputs hex_mon_t, hex_mon_o, hex_day_t, hex_day_o, each 8 bits.
  - Encoding: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex). Bit7 is the decimal point, always 1 (off).
  - Tens digits equal to 0 are blanked to FF.
  - Loaded on the same edge as done.
  - Reset value: FF, C0→F9 pattern for 01-01, i.e. FF, F9, FF, F9.
- Undefined: these ports and their registers do not exist.

Test Plan:
- Reset, then start with doy=1, leap=0 → done at E0+2; month=1, day=1, BCD 0,1,0,1; err=0.
- doy=365, leap=0 → done at E0+16; month=12, day=31, BCD 1,2,3,1.
- doy=60, leap=1 → 02-29, done at E0+5. Same input with leap=0 → 03-01, done at E0+4.
- doy=366, leap=0, and doy=0 → done and err at E0, single pulse; prior outputs unchanged. doy=366, leap=1 → 12-31, err=0.
- start doy=200 (07-19); pulse start with doy=5 on the 3rd busy cycle → ignored; result 07-19 at E0+9.
- Assert rst during WALK of doy=300 → outputs immediately 01-01, busy=0, no done pulse. After release, start doy=32 → 02-01.
